// File: rtl/apu_ipc_mbox.sv
// Inter-hart mailbox: one receive FIFO per hart behind a single AHB-Lite slave.
// Every register is banked by the requesting hart (ahbls_hmaster captured in the address phase).
module apu_ipc_mbox #(
   parameter int DEPTH   = 4,
   parameter int W_LEVEL = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ahbls_haddr,
   input  logic [1:0]  ahbls_htrans,
   input  logic        ahbls_hwrite,
   input  logic [2:0]  ahbls_hsize,
   input  logic        ahbls_hready,
   output logic        ahbls_hready_resp,
   input  logic [31:0] ahbls_hwdata,
   output logic [31:0] ahbls_hrdata,
   output logic        ahbls_hresp,
   input  logic        ahbls_hmaster,
   output logic [1:0]  mbox_irq
);

   localparam int W_PTR = $clog2(DEPTH);

   logic                          dph_valid;
   logic                          dph_write;
   logic                          dph_master;
   logic                          dph_size_ok;
   logic [1:0]                    dph_addr;

   logic [31:0]                   mem [2][DEPTH];
   logic [1:0][W_PTR-1:0]         wptr;
   logic [1:0][W_PTR-1:0]         rptr;
   logic [1:0][W_LEVEL-1:0]       level;
   logic [1:0]                    wof;
   logic [1:0]                    roe;
   logic [1:0]                    irq_en;

   logic        dph_active;
   logic        rx;
   logic        tx;
   logic        rx_empty;
   logic        tx_full;
   logic        push;
   logic        pop;
   logic        wof_set;
   logic        roe_set;
   logic        stat_wr;
   logic        en_wr;
   logic [31:0] stat;
   logic [31:0] rdata;
   logic        unused_ok;

   assign ahbls_hready_resp = 1'b1;
   assign ahbls_hresp       = 1'b0;
   assign unused_ok         = ^{ahbls_haddr[15:4], ahbls_haddr[1:0], ahbls_htrans[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_valid   <= 1'b0;
         dph_write   <= 1'b0;
         dph_master  <= 1'b0;
         dph_size_ok <= 1'b0;
         dph_addr    <= 2'b00;
      end else if (ahbls_hready) begin
         dph_valid   <= ahbls_htrans[1];
         dph_write   <= ahbls_hwrite;
         dph_master  <= ahbls_hmaster;
         dph_size_ok <= (ahbls_hsize == 3'b010);
         dph_addr    <= ahbls_haddr[3:2];
      end
   end

   // The accessing hart receives on its own FIFO and transmits into the other one.
   assign dph_active = dph_valid & dph_size_ok;
   assign rx         = dph_master;
   assign tx         = ~dph_master;
   assign rx_empty   = (level[rx] == '0);
   assign tx_full    = (level[tx] == W_LEVEL'(DEPTH));

   assign push    = dph_active &  dph_write & (dph_addr == 2'd0) & ~tx_full;
   assign wof_set = dph_active &  dph_write & (dph_addr == 2'd0) &  tx_full;
   assign pop     = dph_active & ~dph_write & (dph_addr == 2'd1) & ~rx_empty;
   assign roe_set = dph_active & ~dph_write & (dph_addr == 2'd1) &  rx_empty;
   assign stat_wr = dph_active &  dph_write & (dph_addr == 2'd2);
   assign en_wr   = dph_active &  dph_write & (dph_addr == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr   <= '0;
         rptr   <= '0;
         level  <= '0;
         wof    <= 2'b00;
         roe    <= 2'b00;
         irq_en <= 2'b00;
      end else begin
         // A single slave port means push and pop never hit the same cycle.
         if (push) begin
            wptr[tx]  <= wptr[tx] + 1'b1;
            level[tx] <= level[tx] + 1'b1;
         end
         if (pop) begin
            rptr[rx]  <= rptr[rx] + 1'b1;
            level[rx] <= level[rx] - 1'b1;
         end
         if (wof_set) wof[rx] <= 1'b1;
         if (roe_set) roe[rx] <= 1'b1;
         if (stat_wr) begin
            if (ahbls_hwdata[2]) wof[rx] <= 1'b0;
            if (ahbls_hwdata[3]) roe[rx] <= 1'b0;
         end
         if (en_wr) irq_en[rx] <= ahbls_hwdata[0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tx][wptr[tx]] <= ahbls_hwdata;
   end

   always_comb begin
      stat                = '0;
      stat[0]             = ~rx_empty;
      stat[1]             = ~tx_full;
      stat[2]             = wof[rx];
      stat[3]             = roe[rx];
      stat[8 +: W_LEVEL]  = level[rx];
   end

   always_comb begin
      rdata = '0;
      if (dph_active && !dph_write) begin
         case (dph_addr)
            2'd1:    if (!rx_empty) rdata = mem[rx][rptr[rx]];
            2'd2:    rdata = stat;
            2'd3:    rdata[0] = irq_en[rx];
            default: rdata = '0;
         endcase
      end
   end

   assign ahbls_hrdata = rdata;
   assign mbox_irq[0]  = irq_en[0] & (level[0] != '0);
   assign mbox_irq[1]  = irq_en[1] & (level[1] != '0);

endmodule

// File: tb/tb_apu_ipc_mbox.sv
// Self-checking bench for apu_ipc_mbox: directed sequence plus random traffic,
// all checked against a queue-based model of the per-hart register view.
module tb_apu_ipc_mbox;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ahbls_haddr;
   logic [1:0]  ahbls_htrans;
   logic        ahbls_hwrite;
   logic [2:0]  ahbls_hsize;
   logic        ahbls_hready;
   logic        ahbls_hready_resp;
   logic [31:0] ahbls_hwdata;
   logic [31:0] ahbls_hrdata;
   logic        ahbls_hresp;
   logic        ahbls_hmaster;
   logic [1:0]  mbox_irq;

   apu_ipc_mbox #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ahbls_haddr       (ahbls_haddr),
      .ahbls_htrans      (ahbls_htrans),
      .ahbls_hwrite      (ahbls_hwrite),
      .ahbls_hsize       (ahbls_hsize),
      .ahbls_hready      (ahbls_hready),
      .ahbls_hready_resp (ahbls_hready_resp),
      .ahbls_hwdata      (ahbls_hwdata),
      .ahbls_hrdata      (ahbls_hrdata),
      .ahbls_hresp       (ahbls_hresp),
      .ahbls_hmaster     (ahbls_hmaster),
      .mbox_irq          (mbox_irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: q0/q1 are the receive queues of hart 0/1.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   bit [1:0]    wof, roe, en;

   // Transfer currently in its data phase.
   bit          p_v, p_m, p_w;
   logic [1:0]  p_a;
   logic [2:0]  p_sz;
   logic [31:0] p_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lvl(input bit h);
      return h ? q1.size() : q0.size();
   endfunction

   function automatic logic [31:0] model_read(input bit m, input logic [1:0] a, input logic [2:0] sz);
      logic [31:0] r;
      r = '0;
      if (sz != 3'd2) return r;
      case (a)
         2'd1: begin
            if (lvl(m) == 0) roe[m] = 1'b1;
            else if (m) r = q1.pop_front();
            else r = q0.pop_front();
         end
         2'd2: r = 32'((lvl(m) != 0 ? 1 : 0) + (lvl(!m) < DEPTH ? 2 : 0) +
                       (wof[m] ? 4 : 0) + (roe[m] ? 8 : 0) + lvl(m) * 256);
         2'd3: r = {31'b0, en[m]};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic void model_write(input bit m, input logic [1:0] a, input logic [2:0] sz,
                                       input logic [31:0] d);
      if (sz != 3'd2) return;
      case (a)
         2'd0: begin
            if (lvl(!m) < DEPTH) begin
               if (m) q0.push_back(d);
               else q1.push_back(d);
            end else wof[m] = 1'b1;
         end
         2'd2: begin
            if (d[2]) wof[m] = 1'b0;
            if (d[3]) roe[m] = 1'b0;
         end
         2'd3: en[m] = d[0];
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      q0.delete();
      q1.delete();
      wof = '0;
      roe = '0;
      en  = '0;
      p_v = 1'b0;
   endfunction

   function automatic logic [1:0] model_irq();
      return {en[1] & (q1.size() != 0), en[0] & (q0.size() != 0)};
   endfunction

   // One bus cycle: present a new address phase, complete the previous data phase.
   task automatic step(input bit v, input bit m, input bit w, input logic [1:0] a,
                       input logic [2:0] sz, input logic [31:0] d);
      logic [31:0] exp;
      ahbls_htrans  = v ? 2'b10 : 2'b00;
      ahbls_hmaster = m;
      ahbls_hwrite  = w;
      ahbls_haddr   = {12'($urandom()), a, 2'($urandom())};
      ahbls_hsize   = sz;
      ahbls_hwdata  = p_d;
      @(negedge clk);
      chk("irq", {30'b0, mbox_irq}, {30'b0, model_irq()});
      if (p_v) begin
         if (p_w) model_write(p_m, p_a, p_sz, p_d);
         else begin
            exp = model_read(p_m, p_a, p_sz);
            chk($sformatf("rdata h%0d a%0d sz%0d", p_m, p_a, p_sz), ahbls_hrdata, exp);
         end
      end else begin
         chk("idle_rdata", ahbls_hrdata, 32'h0);
      end
      @(posedge clk);
      #1;
      p_v  = v;
      p_m  = m;
      p_w  = w;
      p_a  = a;
      p_sz = sz;
      p_d  = d;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 32'h0);
   endtask

   task automatic wr(input bit m, input logic [1:0] a, input logic [31:0] d,
                     input logic [2:0] sz = 3'd2);
      step(1'b1, m, 1'b1, a, sz, d);
      idle();
   endtask

   task automatic rd(input bit m, input logic [1:0] a, input logic [2:0] sz = 3'd2);
      step(1'b1, m, 1'b0, a, sz, 32'h0);
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      ahbls_haddr   = '0;
      ahbls_htrans  = 2'b00;
      ahbls_hwrite  = 1'b0;
      ahbls_hsize   = 3'd2;
      ahbls_hready  = 1'b1;
      ahbls_hwdata  = '0;
      ahbls_hmaster = 1'b0;
      model_reset();
      p_m = 0; p_w = 0; p_a = 0; p_sz = 3'd2; p_d = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("reset_irq", {30'b0, mbox_irq}, 32'h0);
      chk("hready_resp", {31'b0, ahbls_hready_resp}, 32'h1);
      chk("hresp", {31'b0, ahbls_hresp}, 32'h0);
      rd(0, 2'd2);

      // Single word hart 0 -> hart 1 with interrupt
      wr(1, 2'd3, 32'h1);
      wr(0, 2'd0, 32'hDEAD_BEEF);
      chk("irq1_high", {30'b0, mbox_irq}, 32'h2);
      rd(1, 2'd2);
      rd(1, 2'd3);
      rd(1, 2'd1);
      chk("irq1_low", {30'b0, mbox_irq}, 32'h0);

      // Overflow hart 1 -> hart 0, drain, underflow
      for (int i = 1; i <= DEPTH + 1; i++) wr(1, 2'd0, 32'(i));
      rd(1, 2'd2);
      for (int i = 0; i < DEPTH; i++) rd(0, 2'd1);
      rd(0, 2'd2);
      rd(0, 2'd1);
      rd(0, 2'd2);
      rd(1, 2'd2);

      // Flag clearing is per hart
      wr(0, 2'd2, 32'hC);
      rd(0, 2'd2);
      rd(1, 2'd2);
      wr(1, 2'd2, 32'h4);
      rd(1, 2'd2);

      // Back-to-back push/pop across pointer wrap
      wr(0, 2'd3, 32'h1);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step(1'b1, 1'b1, 1'b1, 2'd0, 3'd2, $urandom());
         step(1'b1, 1'b0, 1'b0, 2'd1, 3'd2, 32'h0);
      end
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step(1'b1, 1'b0, 1'b1, 2'd0, 3'd2, $urandom());
         if (i % 3 == 2) step(1'b1, 1'b1, 1'b0, 2'd2, 3'd2, 32'h0);
         if (i % 2 == 1) step(1'b1, 1'b1, 1'b0, 2'd1, 3'd2, 32'h0);
      end
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 2'd1, 3'd2, 32'h0);
      idle();
      rd(1, 2'd2);

      // Invalid sizes have no side effect
      wr(0, 2'd0, 32'h1234_5678);
      wr(0, 2'd0, 32'hBAD0_0000, 3'd0);
      rd(1, 2'd1, 3'd1);
      rd(1, 2'd2, 3'd1);
      rd(1, 2'd2);
      rd(1, 2'd1);
      rd(1, 2'd1, 3'd3);
      rd(1, 2'd2);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         step(bit'($urandom_range(0, 4) != 0), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'd2,
              $urandom());
      end
      idle();

      // Reset mid-transfer with two entries queued for hart 1
      wr(1, 2'd3, 32'h1);
      rd(1, 2'd2);
      while (q1.size() != 0) rd(1, 2'd1);
      wr(0, 2'd0, 32'hA5A5_0001);
      wr(0, 2'd0, 32'hA5A5_0002);
      rd(1, 2'd2);
      step(1'b1, 1'b0, 1'b1, 2'd0, 3'd2, 32'hA5A5_0003);
      ahbls_htrans = 2'b00;
      ahbls_hwdata = 32'hA5A5_0003;
      rst_n = 1'b0;
      model_reset();
      p_d = 32'h0;
      @(negedge clk);
      chk("irq_in_reset", {30'b0, mbox_irq}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      rd(1, 2'd3);
      rd(1, 2'd2);
      rd(0, 2'd2);
      rd(1, 2'd1);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
